// File: rtl/soc_boot_loader_if.sv
// Wishbone master/slave bundle used by the boot-ROM copy engine.
// Word addressing; stb mirrors cyc in this single-beat protocol.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

interface soc_boot_loader_if;
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [`WB_ADDR_W-1:0] wb_adr;
  logic [`RW-1:0]        wb_o_dat;
  logic [`RW-1:0]        wb_i_dat;
  logic                  wb_ack;
  logic                  wb_err;

  modport master (
    output wb_cyc,
    output wb_stb,
    output wb_we,
    output wb_adr,
    output wb_o_dat,
    input  wb_i_dat,
    input  wb_ack,
    input  wb_err
  );

  modport slave (
    input  wb_cyc,
    input  wb_stb,
    input  wb_we,
    input  wb_adr,
    input  wb_o_dat,
    output wb_i_dat,
    output wb_ack,
    output wb_err
  );
endinterface

// File: rtl/soc_boot_loader.sv
// Boot loader: copies LEN words from boot ROM to RAM over Wishbone.
// One idle bus cycle separates every read and write access.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

module soc_boot_loader #(
  parameter logic [`WB_ADDR_W-1:0] SRC_BASE = `WB_ADDR_W'('hffe000),
  parameter logic [`WB_ADDR_W-1:0] DST_BASE = '0,
  parameter int unsigned           LEN      = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  soc_boot_loader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FINISH
  } state_t;

  localparam logic [15:0] LAST = 16'(LEN - 1);

  state_t                state_q, state_d;
  logic [15:0]           idx_q, idx_d;
  logic [`RW-1:0]        data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [`WB_ADDR_W-1:0] adr_q, adr_d;
  logic [`RW-1:0]        odat_q, odat_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      odat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      odat_q  <= odat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    odat_d  = odat_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          err_d  = 1'b0;
          idx_d  = '0;
          busy_d = 1'b1;
          if (LEN == 0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = SRC_BASE;
          end
        end
      end
      READ: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          we_d  = 1'b0;
          adr_d = SRC_BASE + `WB_ADDR_W'(idx_q);
        end else if (bus.wb_err) begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end else if (bus.wb_ack) begin
          state_d = WRITE;
          data_d  = bus.wb_i_dat;
          cyc_d   = 1'b0;
        end
      end
      WRITE: begin
        if (!cyc_q) begin
          cyc_d  = 1'b1;
          we_d   = 1'b1;
          adr_d  = DST_BASE + `WB_ADDR_W'(idx_q);
          odat_d = data_q;
        end else if (bus.wb_err) begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end else if (bus.wb_ack) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (idx_q == LAST) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            idx_d   = idx_q + 16'd1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign bus.wb_cyc   = cyc_q;
  assign bus.wb_stb   = cyc_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_adr   = adr_q;
  assign bus.wb_o_dat = odat_q;

endmodule

// File: tb/tb_soc_boot_loader.sv
// Directed bench for soc_boot_loader: ROM/RAM slave with wait states,
// error injection, reset abort, LEN=0 and address wrap instances.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

module tb_soc_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic busy0, done0, err0;
  logic busy1, done1, err1;
  logic busy2, done2, err2;

  int n_vec = 0;
  int n_miss = 0;

  soc_boot_loader_if bus0 ();
  soc_boot_loader_if bus1 ();
  soc_boot_loader_if bus2 ();

  always #5 clk = ~clk;

  soc_boot_loader u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0),
    .o_busy(busy0), .o_done(done0), .o_err(err0), .bus(bus0)
  );

  soc_boot_loader #(.LEN(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .bus(bus1)
  );

  soc_boot_loader #(.SRC_BASE(24'hffffff), .LEN(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .bus(bus2)
  );

  logic [15:0] rom [14] = '{
    16'h0000, 16'h0000, 16'h0004, 16'h0000, 16'h0005, 16'h0000, 16'h0004,
    16'h0000, 16'h0002, 16'h0000, 16'h0008, 16'h0002, 16'h000e, 16'h0002
  };

  function automatic logic [15:0] rom_at(input logic [23:0] a);
    logic [23:0] off;
    off = a - 24'hffe000;
    if (off < 24'd14) return rom[off[3:0]];
    return 16'hdead;
  endfunction

  // u0 slave: ack after waitn stall cycles; optional error on write to 5
  int   waitn = 0;
  int   wcnt = 0;
  logic err_en = 1'b0;

  assign bus0.wb_i_dat = rom_at(bus0.wb_adr);
  assign bus0.wb_ack = bus0.wb_cyc & bus0.wb_stb & (wcnt == waitn);
  assign bus0.wb_err = bus0.wb_cyc & bus0.wb_stb & bus0.wb_we & err_en
                     & (bus0.wb_adr == 24'h5) & (wcnt == waitn);

  always @(posedge clk)
    if (bus0.wb_cyc & bus0.wb_stb & !bus0.wb_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;

  int rd_n = 0, done_n = 0, busy_n = 0, unstable = 0, proto = 0;
  logic [23:0] wr_adr_q [$];
  logic [15:0] wr_dat_q [$];
  logic        pend = 1'b0;
  logic [23:0] p_adr = '0;
  logic        p_we = 1'b0;
  logic [15:0] p_dat = '0;

  always @(negedge clk) begin
    if (bus0.wb_cyc & bus0.wb_stb & bus0.wb_ack & !bus0.wb_err) begin
      if (bus0.wb_we) begin
        wr_adr_q.push_back(bus0.wb_adr);
        wr_dat_q.push_back(bus0.wb_o_dat);
      end else rd_n <= rd_n + 1;
    end
    if (pend && (!bus0.wb_stb || bus0.wb_adr != p_adr
        || bus0.wb_we != p_we || bus0.wb_o_dat != p_dat))
      unstable <= unstable + 1;
    pend  <= bus0.wb_cyc & bus0.wb_stb & !bus0.wb_ack & !bus0.wb_err;
    p_adr <= bus0.wb_adr;
    p_we  <= bus0.wb_we;
    p_dat <= bus0.wb_o_dat;
    if ((!bus0.wb_cyc && bus0.wb_we) || (bus0.wb_stb != bus0.wb_cyc)
        || (bus0.wb_cyc && !busy0))
      proto <= proto + 1;
    if (done0) done_n <= done_n + 1;
    if (busy0) busy_n <= busy_n + 1;
  end

  // u1 must never touch the bus; u2 is a zero-wait slave
  int cyc1_n = 0;
  logic [23:0] rd2_q [$];
  assign bus1.wb_ack = bus1.wb_cyc & bus1.wb_stb;
  assign bus1.wb_err = 1'b0;
  assign bus1.wb_i_dat = 16'h1111;
  assign bus2.wb_ack = bus2.wb_cyc & bus2.wb_stb;
  assign bus2.wb_err = 1'b0;
  assign bus2.wb_i_dat = bus2.wb_adr[15:0];

  always @(negedge clk) begin
    if (bus1.wb_cyc) cyc1_n <= cyc1_n + 1;
    if (bus2.wb_cyc & bus2.wb_stb & bus2.wb_ack & !bus2.wb_we)
      rd2_q.push_back(bus2.wb_adr);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic pulse0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic wait_end0(input string tag);
    int t;
    t = 0;
    while (!(done0 || err0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk(tag, 1, 0);
  endtask

  task automatic chk_log(input string tag, input int base, input int cnt);
    int bad;
    bad = 0;
    if (wr_adr_q.size() < base + cnt) bad = 100;
    else
      for (int i = 0; i < cnt; i++)
        if (wr_adr_q[base+i] != 24'(i) || wr_dat_q[base+i] != rom[i])
          bad++;
    chk(tag, bad, 0);
  endtask

  int b_wr, b_rd, b_done, b_busy, b_uns;

  task automatic snap();
    b_wr   = wr_adr_q.size();
    b_rd   = rd_n;
    b_done = done_n;
    b_busy = busy_n;
    b_uns  = unstable;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_cyc", bus0.wb_cyc, 0);
    chk("rst_stb", bus0.wb_stb, 0);
    chk("rst_we", bus0.wb_we, 0);
    chk("rst_adr", bus0.wb_adr, 0);
    chk("rst_dat", bus0.wb_o_dat, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // zero-wait copy with extra starts while busy and in the done cycle
    snap();
    pulse0();
    repeat (10) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait_end0("to_zw");
    chk("zw_done_pulse", done0, 1);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    chk("zw_done_len", done0, 0);
    chk("zw_idle", busy0, 0);
    chk("zw_busy_cyc", busy_n - b_busy, 56);
    chk("zw_reads", rd_n - b_rd, 14);
    chk("zw_writes", wr_adr_q.size() - b_wr, 14);
    chk("zw_dones", done_n - b_done, 1);
    chk("zw_err", err0, 0);
    chk_log("zw_ram", b_wr, 14);

    // three wait states per access
    repeat (2) @(negedge clk);
    waitn = 3;
    snap();
    pulse0();
    wait_end0("to_ws");
    @(negedge clk);
    chk("ws_busy_cyc", busy_n - b_busy, 140);
    chk("ws_stable", unstable - b_uns, 0);
    chk("ws_writes", wr_adr_q.size() - b_wr, 14);
    chk_log("ws_ram", b_wr, 14);

    // bus error on write to 000005
    waitn = 0;
    err_en = 1'b1;
    snap();
    pulse0();
    wait_end0("to_er");
    chk("er_flag", err0, 1);
    chk("er_cyc", bus0.wb_cyc, 0);
    chk("er_busy", busy0, 0);
    chk("er_nodone", done0, 0);
    repeat (3) @(negedge clk);
    chk("er_sticky", err0, 1);
    chk("er_quiet", bus0.wb_cyc, 0);
    chk("er_dones", done_n - b_done, 0);
    chk("er_writes", wr_adr_q.size() - b_wr, 5);
    chk_log("er_ram", b_wr, 5);

    // restart clears the error and begins at index 0
    err_en = 1'b0;
    snap();
    pulse0();
    chk("rs_err_clr", err0, 0);
    chk("rs_adr", bus0.wb_adr, 32'hffe000);
    chk("rs_rd", {bus0.wb_cyc, bus0.wb_we}, 2'b10);
    wait_end0("to_rs");
    @(negedge clk);
    chk("rs_writes", wr_adr_q.size() - b_wr, 14);
    chk_log("rs_ram", b_wr, 14);

    // reset during the third read, with start and ack in the same cycle
    waitn = 3;
    snap();
    pulse0();
    t = 0;
    while (!(rd_n - b_rd == 2 && bus0.wb_cyc && !bus0.wb_we) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("to_rr", 1, 0);
    waitn = 0;
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    chk("rr_cyc", bus0.wb_cyc, 0);
    chk("rr_busy", busy0, 0);
    chk("rr_adr", bus0.wb_adr, 0);
    repeat (4) @(negedge clk);
    chk("rr_idle", busy0, 0);
    chk("rr_dones", done_n - b_done, 0);
    chk("proto", proto, 0);

    // LEN=0 instance
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("l0_busy", busy1, 1);
    chk("l0_done", done1, 1);
    @(negedge clk);
    chk("l0_busy_end", busy1, 0);
    chk("l0_done_end", done1, 0);
    chk("l0_nocyc", cyc1_n, 0);

    // source wrap from ffffff
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    t = 0;
    while (!done2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("to_wr", 1, 0);
    chk("wr_reads", rd2_q.size(), 2);
    if (rd2_q.size() == 2) begin
      chk("wr_rd0", rd2_q[0], 32'hffffff);
      chk("wr_rd1", rd2_q[1], 32'h000000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/soc_boot_loader.md
SOC_BOOT_LOADER -- requirements
Module: soc_boot_loader

Interface
REQ-001 SHALL have parameter SRC_BASE, default `WB_ADDR_W'hffe000, first boot-ROM word address read.
REQ-002 SHALL have parameter DST_BASE, default `WB_ADDR_W'h000000, first RAM word address written.
REQ-003 SHALL have parameter LEN, default 14, number of `RW-bit words copied (0..65535).
REQ-004 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port i_start  input  1  one-cycle pulse requesting a copy.
REQ-007 SHALL have port o_busy  output  1  high while a copy is in progress.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse on successful completion.
REQ-009 SHALL have port o_err  output  1  sticky bus-error flag.
REQ-010 SHALL have port wb_cyc  output  1  Wishbone cycle.
REQ-011 SHALL have port wb_stb  output  1  Wishbone strobe.
REQ-012 SHALL have port wb_we  output  1  Wishbone write enable.
REQ-013 SHALL have port wb_adr  output  `WB_ADDR_W  Wishbone word address.
REQ-014 SHALL have port wb_o_dat  output  `RW  Wishbone write data.
REQ-015 SHALL have port wb_i_dat  input  `RW  Wishbone read data.
REQ-016 SHALL have port wb_ack  input  1  Wishbone acknowledge.
REQ-017 SHALL have port wb_err  input  1  Wishbone error.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, FINISH; all outputs registered.
REQ-019 IDLE: i_start high -> clear o_err, index=0, go READ next cycle (FINISH if LEN==0).
REQ-020 READ: wb_cyc=wb_stb=1, wb_we=0, wb_adr=SRC_BASE+index; held stable until wb_ack or wb_err.
REQ-021 READ with wb_ack: latch wb_i_dat into data register, go WRITE; wb_cyc/wb_stb drop for exactly one cycle between READ and WRITE.
REQ-022 WRITE: wb_cyc=wb_stb=wb_we=1, wb_adr=DST_BASE+index, wb_o_dat=latched word; held stable until wb_ack or wb_err.
REQ-023 WRITE with wb_ack: index==LEN-1 -> FINISH, else index+1 and READ (after one idle bus cycle).
REQ-024 FINISH: o_done=1 for exactly one cycle, then IDLE.
REQ-025 wb_err in READ or WRITE (wins over simultaneous wb_ack): set o_err, drop bus next cycle, go IDLE, no o_done.
REQ-026 Address sums SHALL be `WB_ADDR_W bits, wrapping modulo 2^`WB_ADDR_W; index counter 16 bits.
REQ-027 o_busy SHALL be 1 in READ, WRITE, FINISH; 0 in IDLE.
REQ-028 i_start while o_busy=1 SHALL be ignored; i_start in the o_done cycle is ignored.
REQ-029 wb_cyc/wb_stb SHALL never assert outside READ/WRITE; wb_we=0 whenever wb_cyc=0.
REQ-030 Minimum per-word cost: 4 cycles with zero-wait acks (READ, gap, WRITE, gap).

Reset
REQ-031 i_rst SHALL force IDLE, index=0, data=0, o_busy=0, o_done=0, o_err=0, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_o_dat=0 on the next edge.
REQ-032 i_rst mid-transfer SHALL drop wb_cyc/wb_stb on that edge, abandon the copy, no o_done.
REQ-033 i_rst takes precedence over i_start and wb_ack in the same cycle.

Verification
REQ-034 Defaults, ROM model returning 16'h0000,0000,0004,0000,0005,0000,0004,0000,0002,0000,0008,0002,000e,0002 at ffe000..ffe00d, zero-wait acks, pulse i_start -> 14 reads then writes to 000000..00000d with same data in order, o_done one cycle, o_err=0.
REQ-035 Slave inserting 3 wait cycles per ack -> wb_adr/wb_we/wb_o_dat stable throughout each stretch, identical RAM contents.
REQ-036 wb_err on the write to 000005 -> o_err=1, bus idle next cycle, no o_done, words 000000..000004 written only; next i_start clears o_err and restarts from index 0.
REQ-037 LEN=0 -> o_busy one cycle, o_done pulse, no wb_cyc; SRC_BASE=ffffff, LEN=2 -> second read at 000000.
REQ-038 i_rst asserted during third READ -> wb_cyc=0 next cycle, o_busy=0, no o_done; i_start during busy -> no effect on word count.
